// File: rtl/datatap_event_capture.sv
// -----------------------------------------------------------------------------
// datatap_event_capture
//
// Watches three tapped core status bits and records every change as a
// timestamped event in a small FIFO. Each record carries the free-running
// timestamp of the change, the new tap value and a mask of the bits that
// changed. When the FIFO is full and nothing is being drained, new events are
// dropped and accounted for in a sticky overflow flag plus a saturating
// drop counter.
//
// Ports
//   clock       in   single clock, rising edge
//   reset_n     in   synchronous, active-low reset
//   tap_in      in   [2:0] tapped status bits
//   enable      in   event capture enable
//   out_valid   out  head record available
//   out_ready   in   consumer accepts the head record
//   out_data    out  [TS_W+5:0] {timestamp, new tap value, change mask}
//   clear_ovf   in   clears overflow and drop_count
//   overflow    out  sticky: at least one event was dropped
//   drop_count  out  [7:0] saturating count of dropped events
// -----------------------------------------------------------------------------
module datatap_event_capture #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [2:0]      tap_in,
    input  logic            enable,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TS_W+5:0] out_data,
    input  logic            clear_ovf,
    output logic            overflow,
    output logic [7:0]      drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = TS_W + 6;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [TS_W-1:0]  ts_q,     ts_d;
    logic [2:0]       tap_q,    tap_d;
    logic             primed_q, primed_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic [7:0]       drop_q,   drop_d;
    logic [REC_W-1:0] mem_q [DEPTH];

    logic             event_w;
    logic             full_w;
    logic             pop_w;
    logic             push_w;
    logic             drop_w;
    logic [REC_W-1:0] rec_w;

    // Event detect: tap_q is refreshed even while disabled, so re-enabling
    // only reports changes that happen after the enable.
    always_comb begin
        event_w = primed_q & enable & (tap_in != tap_q);
        rec_w   = {ts_q, tap_in, tap_in ^ tap_q};
        full_w  = (count_q == CNT_W'(DEPTH));
        pop_w   = (count_q != '0) & out_ready;
        // A full FIFO still accepts an event if the head leaves this cycle.
        push_w  = event_w & (~full_w | pop_w);
        drop_w  = event_w & full_w & ~pop_w;
    end

    always_comb begin
        ts_d     = ts_q + TS_W'(1);
        tap_d    = tap_in;
        primed_d = 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (push_w) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_w && !pop_w) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_w && !push_w) begin
            count_d = count_q - CNT_W'(1);
        end

        // A drop coinciding with a clear is not lost: it restarts the tally.
        if (clear_ovf) begin
            ovf_d  = drop_w;
            drop_d = drop_w ? 8'd1 : 8'd0;
        end else if (drop_w) begin
            ovf_d  = 1'b1;
            drop_d = sat_inc8(drop_q);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ts_q     <= '0;
            tap_q    <= '0;
            primed_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            ts_q     <= ts_d;
            tap_q    <= tap_d;
            primed_q <= primed_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Record storage is not reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (reset_n && push_w) begin
            mem_q[wr_ptr_q] <= rec_w;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_datatap_event_capture.sv
module tb_datatap_event_capture;

    localparam int DEPTH = 4;
    localparam int TS_W  = 16;
    localparam int REC_W = TS_W + 6;

    logic             clock;
    logic             reset_n;
    logic [2:0]       tap_in;
    logic             enable;
    logic             out_valid;
    logic             out_ready;
    logic [REC_W-1:0] out_data;
    logic             clear_ovf;
    logic             overflow;
    logic [7:0]       drop_count;

    datatap_event_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tap_in     (tap_in),
        .enable     (enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .clear_ovf  (clear_ovf),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard and reference state
    logic [REC_W-1:0] sb [$];
    logic [TS_W-1:0]  m_ts;
    logic [2:0]       m_tap;
    bit               m_primed;
    bit               m_ovf;
    int               m_drop;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare outputs against the reference, advance the reference using the
    // inputs currently driven, then step one clock and settle.
    task automatic tick();
        bit pop, ev, full, drop;
        logic [REC_W-1:0] rec;
        chk("valid", out_valid, 64'(sb.size() != 0));
        if (sb.size() == 0) chk("empty_data", out_data, 0);
        chk("overflow", overflow, 64'(m_ovf));
        chk("drop_count", drop_count, 64'(m_drop));
        if (!reset_n) begin
            m_ts = '0; m_tap = '0; m_primed = 0;
            sb.delete(); m_ovf = 0; m_drop = 0;
        end else begin
            pop  = (sb.size() != 0) && out_ready;
            if (pop) chk("pop_data", out_data, sb[0]);
            full = (sb.size() == DEPTH);
            ev   = m_primed && enable && (tap_in != m_tap);
            rec  = {m_ts, tap_in, tap_in ^ m_tap};
            drop = ev && full && !pop;
            if (pop) void'(sb.pop_front());
            if (ev && (!full || pop)) sb.push_back(rec);
            if (clear_ovf) begin
                m_ovf  = drop;
                m_drop = drop ? 1 : 0;
            end else if (drop) begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
            m_tap = tap_in; m_primed = 1; m_ts = m_ts + 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drops", drop_count, 0);
    endtask

    task automatic toggle();
        tap_in = tap_in ^ 3'b001;
    endtask

    logic [TS_W-1:0] prev_ts;
    logic [REC_W-1:0] exp_rec;

    initial begin
        reset_n = 1'b0; tap_in = 3'b000; enable = 1'b1;
        out_ready = 1'b0; clear_ovf = 1'b0;
        m_ts = '0; m_tap = '0; m_primed = 0; m_ovf = 0; m_drop = 0;
        repeat (2) @(posedge clock);
        #1;

        // A: tap already nonzero on the first cycle out of reset -> no event
        do_reset();
        tap_in = 3'b101;
        tick();
        chk("a_first_cycle", out_valid, 0);
        repeat (3) tick();
        chk("a_steady", out_valid, 0);

        // B: change at ts=5 appears next cycle and is popped
        tap_in = 3'b000;
        do_reset();
        out_ready = 1'b1;
        repeat (5) tick();
        tap_in = 3'b010;
        tick();
        chk("b_valid", out_valid, 1);
        exp_rec = {16'd5, 3'b010, 3'b010};
        chk("b_data", out_data, exp_rec);
        tick();
        chk("b_popped", out_valid, 0);

        // C: five back-to-back changes into a 4-deep FIFO, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            toggle();
            tick();
        end
        chk("c_overflow", overflow, 1);
        chk("c_drops", drop_count, 1);
        out_ready = 1'b1;
        prev_ts = out_data[REC_W-1:6] - 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("c_valid", out_valid, 1);
            chk("c_ts_step", out_data[REC_W-1:6], prev_ts + 1'b1);
            prev_ts = out_data[REC_W-1:6];
            tick();
        end
        chk("c_empty", out_valid, 0);

        // D: full FIFO with event and pop in the same cycle -> no drop
        do_reset();
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            toggle();
            tick();
        end
        toggle(); out_ready = 1'b1;
        tick();
        chk("d_no_ovf", overflow, 0);
        chk("d_no_drop", drop_count, 0);
        toggle(); out_ready = 1'b0;
        tick();
        chk("d_still_full", overflow, 1);
        // Reset with records queued discards them all
        do_reset();
        chk("d_rst_empty", out_valid, 0);

        // E: saturating drop counter and clear coinciding with a drop
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 304; i++) begin
            toggle();
            tick();
        end
        chk("e_sat", drop_count, 255);
        chk("e_ovf", overflow, 1);
        toggle(); clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("e_clr_ovf", overflow, 1);
        chk("e_clr_drops", drop_count, 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("e_clr2_ovf", overflow, 0);
        chk("e_clr2_drops", drop_count, 0);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("e_drained", out_valid, 0);

        // F: disabled changes are not reported; timestamp wrap
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tap_in = 3'(i + 3);
            tick();
        end
        enable = 1'b1;
        repeat (3) tick();
        chk("f_no_stale", out_valid, 0);
        for (int i = 0; i < 70000 && m_ts != 16'hFFFF; i++) tick();
        chk("f_wrap_budget", m_ts, 16'hFFFF);
        tick();
        toggle();
        tick();
        chk("f_valid", out_valid, 1);
        chk("f_ts0", out_data[REC_W-1:6], 0);
        tick();
        chk("f_done", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/datatap_event_capture.md
DATATAP_EVENT_CAPTURE -- requirements
Module: datatap_event_capture

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the event FIFO entry count (power of two, 2..16).
REQ-002 The module SHALL have parameter TS_W, default 16, giving the timestamp counter width in bits.
REQ-003 The module SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have port tap_in  input  3  tapped core status bits, driven by the data-tap stage outputs _2.._0 as tap_in[2:0].
REQ-006 The module SHALL have port enable  input  1  event capture enable.
REQ-007 The module SHALL have port out_valid  output  1  FIFO head record available.
REQ-008 The module SHALL have port out_ready  input  1  consumer accepts the head record.
REQ-009 The module SHALL have port out_data  output  TS_W+6  head record: [TS_W+5:6] timestamp, [5:3] new tap value, [2:0] change mask.
REQ-010 The module SHALL have port clear_ovf  input  1  clears overflow and drop_count.
REQ-011 The module SHALL have port overflow  output  1  sticky flag: an event was dropped.
REQ-012 The module SHALL have port drop_count  output  8  saturating count of dropped events.

Function
REQ-013 ts, a TS_W-bit free-running counter, SHALL increment by 1 every cycle out of reset and wrap from all-ones to 0.
REQ-014 tap_q SHALL register tap_in every cycle; primed SHALL be 0 after reset and become 1 after the first post-reset cycle.
REQ-015 An event SHALL occur in a cycle iff primed=1, enable=1 and tap_in != tap_q.
REQ-016 The event record SHALL be {ts, tap_in, tap_in XOR tap_q}, all sampled in the event cycle.
REQ-017 The first post-reset cycle (primed=0) SHALL NOT generate an event, regardless of tap_in.
REQ-018 With enable=0, tap_q SHALL still track tap_in, so that re-enabling does not report stale changes.
REQ-019 The FIFO SHALL hold up to DEPTH records, with write/read pointers of log2(DEPTH) bits that wrap and an occupancy count of log2(DEPTH)+1 bits.
REQ-020 out_valid SHALL equal (count != 0), and out_data SHALL equal the head entry; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-022 A push SHALL occur on an event when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-023 A simultaneous push and pop SHALL leave count unchanged.
REQ-024 Latency SHALL be: an event in cycle N with the FIFO empty gives out_valid=1 in cycle N+1; there is no FIFO bypass.
REQ-025 An event with count == DEPTH and no pop SHALL be dropped: overflow is set to 1, and drop_count increments, saturating at 255.
REQ-026 clear_ovf=1 SHALL clear overflow to 0 and drop_count to 0 next cycle.
REQ-027 A drop in the same cycle as clear_ovf=1 SHALL result in overflow=1 and drop_count=1.
REQ-028 Popping with the FIFO empty is impossible (out_valid=0), and out_ready SHALL be ignored when empty.
REQ-029 FIFO contents SHALL NOT be affected by clear_ovf.

Reset
REQ-030 While reset_n=0 at a clock edge, the block SHALL set ts=0, tap_q=0, primed=0, count=0, rd/wr pointers=0, overflow=0 and drop_count=0.
REQ-031 Out of reset, the outputs SHALL be out_valid=0, out_data=0, overflow=0 and drop_count=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued records within the same edge; no partial record SHALL survive.
REQ-033 FIFO storage need not be reset, but out_data SHALL read 0 whenever count==0.

Verification
REQ-034 The bench SHALL cover: reset, then tap_in=3'b101 held, enable=1 -> no event on the first cycle, out_valid stays 0.
REQ-035 The bench SHALL cover: tap_in 3'b000 -> 3'b010 at ts=5, out_ready=1 -> out_valid=1 next cycle, out_data={16'd5,3'b010,3'b010}, popped that cycle.
REQ-036 The bench SHALL cover: out_ready=0, five tap toggles on consecutive cycles with DEPTH=4 -> count=4, overflow=1, drop_count=1, then four pops return records in order with timestamps increasing by 1.
REQ-037 The bench SHALL cover: FIFO full, an event plus out_ready=1 in the same cycle -> no drop, count stays 4, overflow stays 0.
REQ-038 The bench SHALL cover: 300 dropped events, then clear_ovf=1 coinciding with a further drop -> drop_count=255 before the clear, then overflow=1 and drop_count=1 after.
REQ-039 The bench SHALL cover: enable=0 while tap_in changes, then enable=1 with tap_in steady -> no records; ts wraps 16'hFFFF -> 0 and the record timestamp reads 0.
